// File: rtl/int_divider_seq.sv
// int_divider_seq: sequential signed/unsigned integer divider, radix-2 restoring.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Latency is fixed at WIDTH+2 cycles from accept to out_valid, including
// divide-by-zero and signed-overflow cases.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_signed selects two's-complement mode
//   in_a, in_b        dividend, divisor
//   out_valid/out_ready result handshake; results held while stalled
//   out_q, out_r      quotient, remainder
//   out_dbz, out_ovf  divisor was zero / signed MIN / -1 overflow
module int_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dbz,
  output logic             out_ovf
);

  localparam int               CW   = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw, b_raw;
  logic [WIDTH-1:0] quo;   // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] div;   // divisor magnitude
  logic [WIDTH-1:0] prem;  // partial remainder (always < divisor, so WIDTH bits suffice)
  logic             op_signed, sign_q, sign_r, dbz, ovf;
  logic             accept;
  logic [WIDTH:0]   shifted, diff;

  assign in_ready  = !rst && ((state == IDLE) || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);

  assign shifted = {prem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, div};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first CALC cycle (cnt==0) converts the raw operands captured at accept
  // into magnitudes and flags; cycles cnt=1..WIDTH are the restoring steps.
  // Keeping the negation off the accept path gives the WIDTH+2 latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      a_raw     <= '0;
      b_raw     <= '0;
      quo       <= '0;
      div       <= '0;
      prem      <= '0;
      op_signed <= 1'b0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      a_raw     <= in_a;
      b_raw     <= in_b;
      op_signed <= in_signed;
      cnt       <= '0;
    end else begin
      case (state)
        CALC: begin
          if (cnt == '0) begin
            quo    <= (op_signed && a_raw[WIDTH-1]) ? -a_raw : a_raw;
            div    <= (op_signed && b_raw[WIDTH-1]) ? -b_raw : b_raw;
            prem   <= '0;
            sign_q <= op_signed && (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
            sign_r <= op_signed && a_raw[WIDTH-1];
            dbz    <= (b_raw == '0);
            ovf    <= op_signed && (a_raw == MIN) && (b_raw == '1);
          end else begin
            prem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (dbz) begin
            out_q <= '1;
            out_r <= a_raw;
          end else if (ovf) begin
            out_q <= MIN;
            out_r <= '0;
          end else begin
            out_q <= sign_q ? -quo  : quo;
            out_r <= sign_r ? -prem : prem;
          end
          out_dbz <= dbz;
          out_ovf <= ovf && !dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_divider_seq.sv
module tb_int_divider_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_dbz, out_ovf;
  logic [31:0] out_q, out_r;

  logic        e_in_valid = 1'b0, e_in_signed = 1'b0, e_out_ready = 1'b0;
  logic [7:0]  e_in_a = '0, e_in_b = '0;
  logic        e_in_ready, e_out_valid, e_out_dbz, e_out_ovf;
  logic [7:0]  e_out_q, e_out_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_divider_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_dbz(out_dbz), .out_ovf(out_ovf)
  );

  int_divider_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_signed(e_in_signed),
    .in_a(e_in_a), .in_b(e_in_b),
    .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_q(e_out_q), .out_r(e_out_r), .out_dbz(e_out_dbz), .out_ovf(e_out_ovf)
  );

  // Present one op, let the accepting edge pass, then count edges to out_valid.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release32();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_q !== 32'h0 || out_r !== 32'h0 ||
        out_dbz !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, required 0 0 0 0 0 0",
               in_ready, out_valid, out_q, out_r, out_dbz, out_ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || e_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: in_ready=%b/%b, required 1/1", in_ready, e_in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    run32(32'd100, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'd14 || out_r !== 32'd2 || out_dbz !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL signed_100_7: lat=%0d q=%h r=%h dbz=%b ovf=%b, required 34 0000000e 00000002 0 0",
               lat, out_q, out_r, out_dbz, out_ovf);
    end
    release32();
    run32(32'hFFFFFF9C, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'hFFFFFFF2 || out_r !== 32'hFFFFFFFE || out_dbz !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL signed_m100_7: lat=%0d q=%h r=%h, required 34 fffffff2 fffffffe", lat, out_q, out_r);
    end
    release32();
    // 4294967196 = 7 * 613566742 + 2
    run32(32'hFFFFFF9C, 32'd7, 1'b0, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'h24924916 || out_r !== 32'd2 || out_dbz !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_ff9c_7: lat=%0d q=%h r=%h, required 34 24924916 00000002", lat, out_q, out_r);
    end
    release32();
    run32(32'd100, 32'hFFFFFFF9, 1'b1, lat);
    checks++;
    if (out_q !== 32'hFFFFFFF2 || out_r !== 32'd2) begin
      errors++;
      $display("FAIL signed_100_m7: q=%h r=%h, required fffffff2 00000002", out_q, out_r);
    end
    release32();
  endtask

  task automatic test_dbz();
    int lat;
    run32(32'hFFFFFFFB, 32'd0, 1'b1, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'hFFFFFFFF || out_r !== 32'hFFFFFFFB || out_dbz !== 1'b1 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL dbz_signed: lat=%0d q=%h r=%h dbz=%b ovf=%b, required 34 ffffffff fffffffb 1 0",
               lat, out_q, out_r, out_dbz, out_ovf);
    end
    release32();
    run32(32'd12345, 32'd0, 1'b0, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'hFFFFFFFF || out_r !== 32'd12345 || out_dbz !== 1'b1 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL dbz_unsigned: lat=%0d q=%h r=%h dbz=%b, required 34 ffffffff 00003039 1", lat, out_q, out_r, out_dbz);
    end
    release32();
  endtask

  task automatic test_overflow();
    int lat;
    run32(32'h80000000, 32'hFFFFFFFF, 1'b1, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'h80000000 || out_r !== 32'h0 || out_ovf !== 1'b1 || out_dbz !== 1'b0) begin
      errors++;
      $display("FAIL ovf_signed: lat=%0d q=%h r=%h ovf=%b dbz=%b, required 34 80000000 0 1 0",
               lat, out_q, out_r, out_ovf, out_dbz);
    end
    release32();
    run32(32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'h0 || out_r !== 32'h80000000 || out_ovf !== 1'b0 || out_dbz !== 1'b0) begin
      errors++;
      $display("FAIL ovf_unsigned: lat=%0d q=%h r=%h ovf=%b, required 34 0 80000000 0", lat, out_q, out_r, out_ovf);
    end
    release32();
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    run32(32'd100, 32'd7, 1'b1, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd55; in_b = 32'd5;  // must be ignored while stalled
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 32'd14 || out_r !== 32'd2) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles, required 0", bad);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'd9; in_b = 32'd3; in_signed = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop_valid: out_valid=%b, required 0", out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== 34 || out_q !== 32'd3 || out_r !== 32'd0 || out_dbz !== 1'b0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: lat=%0d q=%h r=%h, required 34 3 0", lat, out_q, out_r);
    end
    release32();
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'd100; in_b = 32'd7; in_signed = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_calc: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready_after: in_ready=%b, required 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_partial: out_valid seen %0d cycles, required 0", seen);
    end
    run32(32'd1, 32'd1, 1'b1, lat);
    checks++;
    if (lat !== 34 || out_q !== 32'd1 || out_r !== 32'd0) begin
      errors++;
      $display("FAIL rst_then_op: lat=%0d q=%h r=%h, required 34 1 0", lat, out_q, out_r);
    end
    release32();
  endtask

  // 8-bit divider over a grid of edge-case operands, checked against SV / and %.
  task automatic test_w8_sweep();
    logic [7:0] vals [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h07, 8'h7E,
                              8'h7F, 8'h80, 8'h81, 8'hC3, 8'hFD, 8'hFE, 8'hFF};
    logic [7:0] a, b, eq, er;
    logic       edbz, eovf, s;
    int         x, y, lat;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 14; i++) begin
        for (int j = 0; j < 14; j++) begin
          a = vals[i]; b = vals[j]; s = (m == 1);
          edbz = 1'b0; eovf = 1'b0;
          if (b == 8'h00) begin
            eq = 8'hFF; er = a; edbz = 1'b1;
          end else if (s && a == 8'h80 && b == 8'hFF) begin
            eq = 8'h80; er = 8'h00; eovf = 1'b1;
          end else if (s) begin
            x = int'($signed(a)); y = int'($signed(b));
            eq = 8'(x / y); er = 8'(x % y);
          end else begin
            eq = a / b; er = a % b;
          end
          @(negedge clk);
          e_in_valid = 1'b1; e_in_a = a; e_in_b = b; e_in_signed = s;
          @(posedge clk);
          #1 e_in_valid = 1'b0;
          lat = 0;
          while (!e_out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
          end
          checks++;
          if (lat !== 10 || e_out_q !== eq || e_out_r !== er || e_out_dbz !== edbz || e_out_ovf !== eovf) begin
            errors++;
            $display("FAIL w8 s=%b a=%h b=%h: lat=%0d q=%h r=%h dbz=%b ovf=%b, required 10 %h %h %b %b",
                     s, a, b, lat, e_out_q, e_out_r, e_out_dbz, e_out_ovf, eq, er, edbz, eovf);
          end
          @(negedge clk);
          e_out_ready = 1'b1;
          @(posedge clk);
          #1 e_out_ready = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dbz();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_w8_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
